key_report_tx: RTL and testbench
================================

# key_report_tx

Transmit-side counterpart to the UART key decoder. Watches the 8-bit game key vector and reports every change as ASCII over a UART TX line, 8N1: lowercase letter on press, uppercase on release. Sits between the game logic's key/status vector and the board TX pin, so the host terminal sees the key state the FPGA is acting on.

## Interface
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `CLK` input 1 — single system clock, rising edge.
- `RESET_N` input 1 — asynchronous, active-low reset.
- `KEYS` input 8 — key vector `{up,down,left,right,j,k,l,atk}`, synchronous to `CLK`.
- `TX` output 1 — UART serial out, idle high.
- `BUSY` output 1 — high while a report is in progress (FSM not IDLE).

## Operation
- Bit-to-character map, bit7..bit0:
  - press: `w` 0x77, `s` 0x73, `a` 0x61, `d` 0x64, `j` 0x6A, `k` 0x6B, `l` 0x6C, space 0x20.
  - release: press code − 0x20, except bit0, which releases as `Z` 0x5A.
- Registers:
  - `reported[7:0]` holds the last reported key state; reset value 0.
  - `snap[7:0]` and `delta[7:0]` hold the key state and changed bits of the report in progress.
- FSM states:
  - IDLE: if `KEYS != reported`, then `snap <= KEYS`, `delta <= KEYS ^ reported`, go to LOAD.
  - LOAD: select the highest set bit i of `delta` and clear it. Byte is the press code if `snap[i]`, otherwise the release code. Pulse `tx_start` (registered, 1 cycle). Go to WAIT.
  - WAIT: when serializer busy is low, go to LOAD if `delta != 0`, otherwise to DONE.
  - DONE: `reported <= snap`, go to IDLE.
- Simultaneous changes in one capture produce one byte per changed bit, MSB first. Example: 0x00→0x81 sends `w` then space.
- Changes to `KEYS` during a report are not lost. They differ from `reported` after DONE and are reported in the next pass.
- A pulse shorter than one report, e.g. press then release within one byte time, is reported only if sampled in IDLE.
- Serializer `uart_tx_serializer` behaviour:
  - Frame: start bit 0, 8 data bits LSB first, one stop bit 1. Each bit lasts `CLKS_PER_BIT` cycles.
  - Its busy output equals `busy_reg | tx_start`.
  - `tx_start` while busy is a protocol error. The FSM never issues one.
- Reset, including mid-frame: `TX`=1 and `BUSY`=0 asynchronously; FSM goes to IDLE; `reported`, `snap` and `delta` go to 0. Keys still held after reset release are reported as presses.

## Timing
- Edge E0: IDLE captures a change.
- Edge E1: `tx_start` high.
- Edge E2: `TX` falls (start bit). The first start bit therefore begins 2 clock edges after capture.
- Frame length: 10·`CLKS_PER_BIT` cycles.
- Back-to-back bytes: exactly 3 idle-high cycles between the end of one stop bit and the next start bit.
- After the last stop bit:
  - WAIT→DONE at +1 cycle.
  - DONE→IDLE at +2; `BUSY` falls there.
  - A pending new change is captured at +3.
- `BUSY` rises on E0 and stays high continuously across all bytes of a report.
- Counter widths: bit counter 4 bits; baud counter `$clog2(CLKS_PER_BIT)` bits, wrapping at `CLKS_PER_BIT`−1.

## Configuration
- `KEY_REPORT_CRLF_EN` defined: after the last character of each report, send CR 0x0D then LF 0x0A via states CR and LF inserted before DONE. CR and LF use the same 3-cycle inter-byte gap.
- Undefined: no terminator; WAIT goes directly to DONE.

## Structure
- Shared package `key_report_pkg`:
  - FSM state enum.
  - Key bit index constants.
  - The 16 press/release character constants; CR and LF.
- One sub-module, `uart_tx_serializer`:
  - Parameter: `CLKS_PER_BIT`.
  - Ports: `CLK`, `RESET_N`, `tx_start`, `tx_byte[7:0]`, `busy`, `tx`.

## Test plan
- Reset with `KEYS`=0: `TX`=1 and `BUSY`=0 throughout; no frames sent.
- Single press, `KEYS` 0x00→0x80 with `CLKS_PER_BIT`=8:
  - start bit 2 edges after capture;
  - one frame carrying 0x77;
  - `BUSY` falls 2 cycles after the stop bit.
- Release 0x80→0x00: one frame carrying 0x57.
- Multi-bit change 0x00→0x81, then 0x81→0x00 after the first report:
  - frames 0x77, 0x20, 0x57, 0x5A in that order;
  - 3-cycle gaps within each report.
- Change during a report: 0x00→0x40, then 0x08 applied mid-frame of `s`.
  - Frames: 0x73, then 0x53 and 0x6A in the second report.
- Assert `RESET_N` mid-data-bit:
  - `TX` goes to 1 immediately;
  - after release with `KEYS`=0x02, a fresh frame 0x6C is sent.
- With `KEY_REPORT_CRLF_EN`, press 0x04: frames 0x6B, 0x0D, 0x0A.

Source files
------------

// File: rtl/key_report_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_report_pkg
// Description : Shared types and constants for the key report transmitter:
//               FSM state encoding, key bit indices, ASCII report characters
//               and small helpers for character and bit selection.
// Revision    : 1.0 - initial release
// ============================================================================
package key_report_pkg;

  // Report FSM states; CR/LF are only reachable with the terminator build.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_CR   = 3'd3,
    ST_LF   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Bit positions inside the key vector {up,down,left,right,j,k,l,atk}.
  localparam logic [2:0] c_KEY_UP    = 3'd7;
  localparam logic [2:0] c_KEY_DOWN  = 3'd6;
  localparam logic [2:0] c_KEY_LEFT  = 3'd5;
  localparam logic [2:0] c_KEY_RIGHT = 3'd4;
  localparam logic [2:0] c_KEY_J     = 3'd3;
  localparam logic [2:0] c_KEY_K     = 3'd2;
  localparam logic [2:0] c_KEY_L     = 3'd1;
  localparam logic [2:0] c_KEY_ATK   = 3'd0;

  // Press characters are lowercase; releases are uppercase (atk uses 'Z').
  localparam logic [7:0] c_CH_UP_PRESS      = 8'h77;
  localparam logic [7:0] c_CH_UP_RELEASE    = 8'h57;
  localparam logic [7:0] c_CH_DOWN_PRESS    = 8'h73;
  localparam logic [7:0] c_CH_DOWN_RELEASE  = 8'h53;
  localparam logic [7:0] c_CH_LEFT_PRESS    = 8'h61;
  localparam logic [7:0] c_CH_LEFT_RELEASE  = 8'h41;
  localparam logic [7:0] c_CH_RIGHT_PRESS   = 8'h64;
  localparam logic [7:0] c_CH_RIGHT_RELEASE = 8'h44;
  localparam logic [7:0] c_CH_J_PRESS       = 8'h6A;
  localparam logic [7:0] c_CH_J_RELEASE     = 8'h4A;
  localparam logic [7:0] c_CH_K_PRESS       = 8'h6B;
  localparam logic [7:0] c_CH_K_RELEASE     = 8'h4B;
  localparam logic [7:0] c_CH_L_PRESS       = 8'h6C;
  localparam logic [7:0] c_CH_L_RELEASE     = 8'h4C;
  localparam logic [7:0] c_CH_ATK_PRESS     = 8'h20;
  localparam logic [7:0] c_CH_ATK_RELEASE   = 8'h5A;
  localparam logic [7:0] c_CH_CR            = 8'h0D;
  localparam logic [7:0] c_CH_LF            = 8'h0A;

  // Index of the highest set bit; reports go out MSB first.
  function automatic logic [2:0] msb_index(input logic [7:0] d);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // ASCII character for key idx, press or release.
  function automatic logic [7:0] key_char(input logic [2:0] idx, input logic pressed);
    logic [7:0] p;
    logic [7:0] r;
    p = c_CH_ATK_PRESS;
    r = c_CH_ATK_RELEASE;
    case (idx)
      c_KEY_UP:    begin p = c_CH_UP_PRESS;    r = c_CH_UP_RELEASE;    end
      c_KEY_DOWN:  begin p = c_CH_DOWN_PRESS;  r = c_CH_DOWN_RELEASE;  end
      c_KEY_LEFT:  begin p = c_CH_LEFT_PRESS;  r = c_CH_LEFT_RELEASE;  end
      c_KEY_RIGHT: begin p = c_CH_RIGHT_PRESS; r = c_CH_RIGHT_RELEASE; end
      c_KEY_J:     begin p = c_CH_J_PRESS;     r = c_CH_J_RELEASE;     end
      c_KEY_K:     begin p = c_CH_K_PRESS;     r = c_CH_K_RELEASE;     end
      c_KEY_L:     begin p = c_CH_L_PRESS;     r = c_CH_L_RELEASE;     end
      c_KEY_ATK:   begin p = c_CH_ATK_PRESS;   r = c_CH_ATK_RELEASE;   end
      default:     begin p = c_CH_ATK_PRESS;   r = c_CH_ATK_RELEASE;   end
    endcase
    return pressed ? p : r;
  endfunction

  // Line terminator character: stage 0 gives CR, stage 1 gives LF.
  function automatic logic [7:0] term_char(input logic stage);
    return stage ? c_CH_LF : c_CH_CR;
  endfunction

endpackage : key_report_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 UART transmitter. A one-cycle tx_start loads a byte and
//               launches start bit, 8 data bits LSB first and one stop bit,
//               each CLKS_PER_BIT cycles long. busy covers the start request
//               cycle so a caller never sees a gap before the frame begins.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned          c_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0]  c_BAUD_MAX  = c_BAUD_W'(CLKS_PER_BIT - 1);
  // Bit slot 0 is the start bit, 1..8 data, 9 the stop bit.
  localparam logic [3:0]           c_BIT_LAST  = 4'd8;
  localparam logic [3:0]           c_BIT_STOP  = 4'd9;

  logic                r_busy;
  logic                r_tx;
  logic [7:0]          r_shift;
  logic [c_BAUD_W-1:0] r_baud;
  logic [3:0]          r_bit;

  // Frame sequencer: baud counter paces bit slots, shift register feeds data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (tx_start) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= tx_byte;
      r_baud  <= '0;
      r_bit   <= '0;
    end else if (r_busy) begin
      if (r_baud == c_BAUD_MAX) begin
        r_baud <= '0;
        if (r_bit == c_BIT_STOP) begin
          r_busy <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == c_BIT_LAST) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

  assign busy = r_busy | tx_start;
  assign tx   = r_tx;

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/key_report_tx.sv
`default_nettype none
// ============================================================================
// Module      : key_report_tx
// Description : Watches the 8-bit key vector and reports every change over
//               UART 8N1: lowercase on press, uppercase on release, one byte
//               per changed bit, MSB first. Changes arriving during a report
//               are picked up by the next pass.
//               Build option KEY_REPORT_CRLF_EN: append CR LF to each report.
// Revision    : 1.0 - initial release
// ============================================================================
module key_report_tx
  import key_report_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] KEYS,
  output logic       TX,
  output logic       BUSY
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_reported;
  logic [7:0] w_reported_nxt;
  logic [7:0] r_snap;
  logic [7:0] w_snap_nxt;
  logic [7:0] r_delta;
  logic [7:0] w_delta_nxt;
  logic [7:0] r_byte;
  logic [7:0] w_byte_nxt;
  logic       r_tx_start;
  logic       w_tx_start_nxt;
  logic [2:0] w_idx;
  logic       w_ser_busy;
`ifdef KEY_REPORT_CRLF_EN
  // Terminator progress: 0 none sent, 1 CR sent, 2 CR and LF sent.
  logic [1:0] r_term;
  logic [1:0] w_term_nxt;
`endif

  // State and report registers; reset clears all history so held keys re-report.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_reported <= '0;
      r_snap     <= '0;
      r_delta    <= '0;
      r_byte     <= '0;
      r_tx_start <= 1'b0;
`ifdef KEY_REPORT_CRLF_EN
      r_term     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_reported <= w_reported_nxt;
      r_snap     <= w_snap_nxt;
      r_delta    <= w_delta_nxt;
      r_byte     <= w_byte_nxt;
      r_tx_start <= w_tx_start_nxt;
`ifdef KEY_REPORT_CRLF_EN
      r_term     <= w_term_nxt;
`endif
    end
  end

  // Next-state logic: capture, emit one byte per changed bit, then commit.
  always_comb begin
    w_state_nxt    = r_state;
    w_reported_nxt = r_reported;
    w_snap_nxt     = r_snap;
    w_delta_nxt    = r_delta;
    w_byte_nxt     = r_byte;
    w_tx_start_nxt = 1'b0;
    w_idx          = msb_index(r_delta);
`ifdef KEY_REPORT_CRLF_EN
    w_term_nxt     = r_term;
`endif
    case (r_state)
      ST_IDLE: begin
        if (KEYS != r_reported) begin
          w_snap_nxt  = KEYS;
          w_delta_nxt = KEYS ^ r_reported;
          w_state_nxt = ST_LOAD;
`ifdef KEY_REPORT_CRLF_EN
          w_term_nxt  = 2'd0;
`endif
        end
      end
      ST_LOAD: begin
        w_delta_nxt    = r_delta & ~(8'b1 << w_idx);
        w_byte_nxt     = key_char(w_idx, r_snap[w_idx]);
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!w_ser_busy) begin
          if (r_delta != '0) begin
            w_state_nxt = ST_LOAD;
          end else begin
`ifdef KEY_REPORT_CRLF_EN
            case (r_term)
              2'd0:    w_state_nxt = ST_CR;
              2'd1:    w_state_nxt = ST_LF;
              default: w_state_nxt = ST_DONE;
            endcase
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef KEY_REPORT_CRLF_EN
      ST_CR: begin
        w_byte_nxt     = term_char(1'b0);
        w_tx_start_nxt = 1'b1;
        w_term_nxt     = 2'd1;
        w_state_nxt    = ST_WAIT;
      end
      ST_LF: begin
        w_byte_nxt     = term_char(1'b1);
        w_tx_start_nxt = 1'b1;
        w_term_nxt     = 2'd2;
        w_state_nxt    = ST_WAIT;
      end
`endif
      ST_DONE: begin
        w_reported_nxt = r_snap;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .tx_start (r_tx_start),
    .tx_byte  (r_byte),
    .busy     (w_ser_busy),
    .tx       (TX)
  );

  assign BUSY = (r_state != ST_IDLE);

endmodule : key_report_tx
`default_nettype wire

// File: tb/tb_key_report_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_report_tx
// Description : Self-checking bench for key_report_tx. A UART monitor decodes
//               frames with their start cycle; directed key vectors with
//               hand-computed characters are checked for content, order,
//               start latency, inter-byte gaps and BUSY timing, plus
//               sequences for mid-report changes and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_report_tx;

  localparam int CPB   = 8;
  localparam int FRAME = 10 * CPB;
`ifdef KEY_REPORT_CRLF_EN
  localparam int TERM  = 2;
`else
  localparam int TERM  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] keys;
  logic       tx;
  logic       busy;

  key_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .KEYS    (keys),
    .TX      (tx),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cnt = 0;
  always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

  typedef struct {
    logic [7:0] b;
    int         st;
    bit         ok;
  } frame_t;
  frame_t rxq[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- UART monitor ----------------
  logic       prev_tx = 1'b1;
  logic [7:0] m_b;
  int         m_st;
  int         m_r0;
  bit         m_ab;
  bit         m_ok;

  task automatic mon_wait(input int n, input int r0, inout bit ab);
    for (int w = 0; w < n && !ab; w++) begin
      @(negedge clk);
      if (rst_n !== 1'b1 || rst_cnt != r0) ab = 1'b1;
    end
  endtask

  always begin : p_mon
    @(negedge clk);
    if (rst_n === 1'b1 && prev_tx === 1'b1 && tx === 1'b0) begin
      m_st = cyc;
      m_r0 = rst_cnt;
      m_ab = 1'b0;
      m_ok = 1'b1;
      mon_wait(CPB / 2, m_r0, m_ab);
      if (tx !== 1'b0) m_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mon_wait(CPB, m_r0, m_ab);
        m_b[i] = tx;
      end
      mon_wait(CPB, m_r0, m_ab);
      if (tx !== 1'b1) m_ok = 1'b0;
      if (!m_ab) rxq.push_back('{b: m_b, st: m_st, ok: m_ok});
    end
    prev_tx = tx;
  end

  // ---------------- helpers ----------------
  // Returns at the first negedge with BUSY low; fall is cyc there (edge index).
  task automatic wait_busy_low(input string tag, output int fall);
    int n;
    n    = 0;
    fall = -1;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 5000);
    if (busy === 1'b0) fall = cyc;
    else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout busy=%b required=0", tag, busy);
    end
  endtask

  task automatic verify_report(input string tag, input int e0, input int fall,
                               input int n, input logic [3:0][7:0] exp);
    int         nexp;
    logic [7:0] eb;
    nexp = (n > 0) ? n + TERM : 0;
    chk({tag, "_nframes"}, rxq.size(), nexp);
    for (int k = 0; k < rxq.size() && k < nexp; k++) begin
      eb = (k < n) ? exp[k] : ((k == n) ? 8'h0D : 8'h0A);
      chk($sformatf("%s_byte%0d", tag, k), int'(rxq[k].b), int'(eb));
      chk($sformatf("%s_frame_ok%0d", tag, k), int'(rxq[k].ok), 1);
      if (k == 0) chk({tag, "_first_start"}, rxq[k].st, e0 + 2);
      else chk($sformatf("%s_gap%0d", tag, k), rxq[k].st - (rxq[k-1].st + FRAME), 3);
    end
    if (nexp > 0 && rxq.size() == nexp)
      chk({tag, "_busy_fall"}, fall, rxq[nexp-1].st + FRAME + 2);
  endtask

  typedef struct {
    logic [7:0]       keys;
    int               n;
    logic [3:0][7:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] k, input int n, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.keys = k;
    v.n    = n;
    v.exp  = {b3, b2, b1, b0};
    return v;
  endfunction

  vec_t tbl[9];

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int e0;
    int fall;
    int fall1;
    int bad;
    int ex_c[$];

    // Reported state entering the table is 0x80 (left by the timing sequence).
    tbl[0] = mk(8'h00, 1, 8'h57, 8'h00, 8'h00, 8'h00);
    tbl[1] = mk(8'h81, 2, 8'h77, 8'h20, 8'h00, 8'h00);
    tbl[2] = mk(8'h00, 2, 8'h57, 8'h5A, 8'h00, 8'h00);
    tbl[3] = mk(8'h3C, 4, 8'h61, 8'h64, 8'h6A, 8'h6B);
    tbl[4] = mk(8'h21, 4, 8'h44, 8'h4A, 8'h4B, 8'h20);
    tbl[5] = mk(8'h00, 2, 8'h41, 8'h5A, 8'h00, 8'h00);
    tbl[6] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[7] = mk(8'h42, 2, 8'h73, 8'h6C, 8'h00, 8'h00);
    tbl[8] = mk(8'h00, 2, 8'h53, 8'h4C, 8'h00, 8'h00);

    // Reset with KEYS=0: line idle, not busy, nothing sent.
    rst_n = 1'b0;
    keys  = 8'h00;
    bad   = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_line_violations", bad, 0);
    chk("idle_frames", rxq.size(), 0);

    // Single press 0x00 -> 0x80: latency, content, BUSY fall.
    rxq.delete();
    keys = 8'h80;
    e0   = cyc + 1;
    @(negedge clk);
    chk("press_busy_rise", int'(busy), 1);
    wait_busy_low("press", fall);
    verify_report("press", e0, fall, 1, {8'h00, 8'h00, 8'h00, 8'h77});

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      rxq.delete();
      keys = tbl[i].keys;
      e0   = cyc + 1;
      wait_busy_low($sformatf("vec%0d", i), fall);
      if (tbl[i].n == 0) repeat (4 * CPB) @(negedge clk);
      verify_report($sformatf("vec%0d", i), e0, fall, tbl[i].n, tbl[i].exp);
      repeat (2) @(negedge clk);
    end

    // Change during a report: 0x00 -> 0x40, then 0x08 mid-frame of 's'.
    rxq.delete();
    keys = 8'h40;
    e0   = cyc + 1;
    repeat (2 + 3 * CPB) @(negedge clk);
    keys = 8'h08;
    wait_busy_low("midchg1", fall1);
    @(negedge clk);
    chk("midchg_recapture_busy", int'(busy), 1);
    wait_busy_low("midchg2", fall);
    ex_c.push_back(8'h73);
`ifdef KEY_REPORT_CRLF_EN
    ex_c.push_back(8'h0D);
    ex_c.push_back(8'h0A);
`endif
    ex_c.push_back(8'h53);
    ex_c.push_back(8'h6A);
`ifdef KEY_REPORT_CRLF_EN
    ex_c.push_back(8'h0D);
    ex_c.push_back(8'h0A);
`endif
    chk("midchg_nframes", rxq.size(), ex_c.size());
    for (int k = 0; k < rxq.size() && k < ex_c.size(); k++)
      chk($sformatf("midchg_byte%0d", k), int'(rxq[k].b), ex_c[k]);
    if (rxq.size() == ex_c.size()) begin
      chk("midchg_first_start", rxq[0].st, e0 + 2);
      chk("midchg_busy_fall1", fall1, rxq[TERM].st + FRAME + 2);
      chk("midchg_second_start", rxq[TERM + 1].st, rxq[TERM].st + FRAME + 5);
      chk("midchg_busy_fall2", fall, rxq[ex_c.size() - 1].st + FRAME + 2);
    end
    repeat (2) @(negedge clk);

    // Reset during data bit 3 of 'w' (a 0 bit), then fresh report of 0x02.
    rxq.delete();
    keys = 8'h80;
    e0   = cyc + 1;
    repeat (5 + 4 * CPB) @(negedge clk);
    chk("rstmid_databit", int'(tx), 0);
    #1;
    rst_n = 1'b0;
    keys  = 8'h02;
    #1;
    chk("rstmid_tx_async", int'(tx), 1);
    chk("rstmid_busy_async", int'(busy), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    e0    = cyc + 1;
    wait_busy_low("rstmid", fall);
    verify_report("rstmid", e0, fall, 1, {8'h00, 8'h00, 8'h00, 8'h6C});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_key_report_tx
`default_nettype wire
